iagc_sample_buffer: RTL and testbench
=====================================

// Module: iagc_sample_buffer
// PURPOSE
//  Multi-channel sample store for the IAGC datapath, next generation of the single-channel sample memory.
//  Captures NUM_CHANNELS samples per strobe into a circular buffer of DEPTH rows. Streams contents oldest-first
//  over a valid/ready dump port and sweeps itself to zero on command. Driven by the IAGC top-level status word.
// PARAMETERS
//  DATA_SIZE         16    width of one channel sample
//  NUM_CHANNELS      4     channels captured per strobe (>=1)
//  CH_SIZE           2     width of channel index, 2**CH_SIZE >= NUM_CHANNELS
//  DEPTH             1024  rows in circular buffer (>=2, need not be power of 2)
//  ADDR_SIZE         10    row index width, 2**ADDR_SIZE >= DEPTH
//  IAGC_STATUS_SIZE  4     width of status word
// PORTS
//  i_clock          in   1                        single clock, all logic on rising edge
//  i_reset          in   1                        synchronous, active-high reset
//  i_iagc_status    in   IAGC_STATUS_SIZE         top-level status: SAMPLE=0011, DUMP_MEM=0111, CLEAN_MEM=1000, others idle
//  i_sample_valid   in   1                        sample strobe, honoured only while status==SAMPLE
//  i_sample_data    in   NUM_CHANNELS*DATA_SIZE   channel k in bits [k*DATA_SIZE +: DATA_SIZE]
//  o_dump_valid     out  1                        dump word present
//  i_dump_ready     in   1                        consumer accepts dump word
//  o_dump_data      out  DATA_SIZE                dump word
//  o_dump_channel   out  CH_SIZE                  channel index of o_dump_data
//  o_dump_last      out  1                        qualifies final word of dump
//  o_dump_end       out  1                        dump complete, held while status==DUMP_MEM
//  o_clean_end      out  1                        sweep complete, held while status==CLEAN_MEM
//  o_count          out  ADDR_SIZE+1              stored rows, saturates at DEPTH
//  o_overflow       out  1                        sticky: a row was overwritten since last clean/reset
// BEHAVIOUR
//  Reset: every output 0; wr_ptr, count, overflow = 0; FSM = IDLE. Memory contents are not reset.
//  FSM states: IDLE, DUMP_FETCH, DUMP_SHOW, DUMP_DONE, CLEAN, CLEAN_DONE. Registered, one transition per edge.
//  Any status not matching the current mode returns FSM to IDLE on the next edge.
//  When the FSM returns to IDLE, valid, last, dump_end and clean_end deassert. A partial dump or clean is abandoned.
//  SAMPLE: on each edge with i_sample_valid=1, write all channels as one row at wr_ptr.
//   - wr_ptr increments, wrapping DEPTH-1 -> 0.
//   - count increments, saturating at DEPTH.
//   - A write while count==DEPTH sets overflow; the oldest row is overwritten.
//  Writes outside SAMPLE are ignored. Sample writes and the clean sweep never coincide, because status is a single value.
//  DUMP entry (IDLE with status==DUMP_MEM):
//   - start row = (count==DEPTH) ? wr_ptr : 0; rows remaining = count; channel = 0.
//   - If count==0, go straight to DUMP_DONE: o_dump_end=1 after the first edge, no valid ever.
//  DUMP_FETCH (1 cycle): synchronous memory read of the current row.
//  DUMP_SHOW:
//   - o_dump_valid=1; data and channel are held stable until a cycle with valid && ready.
//   - On handshake: next channel. After channel NUM_CHANNELS-1, advance to the next row (wrapping DEPTH-1 -> 0)
//     and return to DUMP_FETCH.
//   - o_dump_last=1 on the last channel of the last row. Its handshake moves the FSM to DUMP_DONE.
//   - Word rate: one per two cycles when ready is held high.
//  DUMP leaves wr_ptr, count and overflow unchanged. Re-entering DUMP restarts from the oldest row.
//  CLEAN entry:
//   - wr_ptr, count, overflow cleared on the entry edge.
//   - Row n is zeroed on the (n+1)th edge with status==CLEAN_MEM, for n = 0..DEPTH-1.
//   - o_clean_end rises on the edge after row DEPTH-1 is cleared (CLEAN_DONE) and holds until status changes.
//  Reset mid-operation: takes priority over everything; outputs 0 on the next edge.
//  Width rule: o_count carries the value DEPTH without truncation.
//  Pointer compares use DEPTH, never 2**ADDR_SIZE.
// TESTING
//  Reset -> CLEAN (DEPTH=8): o_clean_end=0 after 8 edges, 1 after the 9th; dump then yields count=0, o_dump_end=1, valid never set.
//  NUM_CHANNELS=2: write 3 rows {0x0B,0x0A},{0x1B,0x1A},{0x2B,0x2A}, dump with ready=1
//   -> data 0x0A,0x0B,0x1A,0x1B,0x2A,0x2B; channel 0,1,0,1,0,1; last only on 0x2B; count=3.
//  Wrap, DEPTH=4, NUM_CHANNELS=1: write 1..6 -> count=4, overflow=1; dump yields 3,4,5,6.
//  Backpressure: hold ready=0 for 5 cycles while valid=1 -> data, channel and last unchanged; no word skipped on release.
//  Abort: leave DUMP_MEM after 2 handshakes, re-enter -> valid drops next edge; restart from oldest word; count unchanged.
//  Reset asserted at row 3 of a clean -> outputs and count 0 next edge; o_clean_end stays 0.

Source files
------------

// File: rtl/iagc_sample_buffer_if.sv
// Sample-capture and dump-stream signal bundle for iagc_sample_buffer.
// master = IAGC control/consumer side, slave = the buffer itself.
interface iagc_sample_buffer_if #(
    parameter int unsigned DATA_SIZE        = 16,
    parameter int unsigned NUM_CHANNELS     = 4,
    parameter int unsigned CH_SIZE          = 2,
    parameter int unsigned ADDR_SIZE        = 10,
    parameter int unsigned IAGC_STATUS_SIZE = 4
) ();
    logic [IAGC_STATUS_SIZE-1:0]       i_iagc_status;
    logic                              i_sample_valid;
    logic [NUM_CHANNELS*DATA_SIZE-1:0] i_sample_data;
    logic                              o_dump_valid;
    logic                              i_dump_ready;
    logic [DATA_SIZE-1:0]              o_dump_data;
    logic [CH_SIZE-1:0]                o_dump_channel;
    logic                              o_dump_last;
    logic                              o_dump_end;
    logic                              o_clean_end;
    logic [ADDR_SIZE:0]                o_count;
    logic                              o_overflow;

    modport master (
        output i_iagc_status, i_sample_valid, i_sample_data, i_dump_ready,
        input  o_dump_valid, o_dump_data, o_dump_channel, o_dump_last,
        input  o_dump_end, o_clean_end, o_count, o_overflow
    );

    modport slave (
        input  i_iagc_status, i_sample_valid, i_sample_data, i_dump_ready,
        output o_dump_valid, o_dump_data, o_dump_channel, o_dump_last,
        output o_dump_end, o_clean_end, o_count, o_overflow
    );
endinterface

// File: rtl/iagc_sample_buffer.sv
// Multi-channel circular sample store: captures one row per strobe, streams rows
// oldest-first over a valid/ready port and sweeps itself to zero on command.
module iagc_sample_buffer #(
    parameter int unsigned DATA_SIZE        = 16,
    parameter int unsigned NUM_CHANNELS     = 4,
    parameter int unsigned CH_SIZE          = 2,
    parameter int unsigned DEPTH            = 1024,
    parameter int unsigned ADDR_SIZE        = 10,
    parameter int unsigned IAGC_STATUS_SIZE = 4
) (
    input logic                  i_clock,
    input logic                  i_reset,
    iagc_sample_buffer_if.slave  bus
);
    localparam int unsigned ROW_W = NUM_CHANNELS * DATA_SIZE;
    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    localparam logic [CNT_W-1:0]            DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_SIZE-1:0]        LAST_ROW  = ADDR_SIZE'(DEPTH - 1);
    localparam logic [CH_SIZE-1:0]          LAST_CH   = CH_SIZE'(NUM_CHANNELS - 1);
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_SAMPLE = IAGC_STATUS_SIZE'(4'b0011);
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_DUMP   = IAGC_STATUS_SIZE'(4'b0111);
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_CLEAN  = IAGC_STATUS_SIZE'(4'b1000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_FETCH,
        S_DUMP_SHOW,
        S_DUMP_DONE,
        S_CLEAN,
        S_CLEAN_DONE
    } state_t;

    state_t               state;
    logic [ROW_W-1:0]     mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [CNT_W-1:0]     rows_left;
    logic [CH_SIZE-1:0]   ch;
    logic [ADDR_SIZE-1:0] clean_ptr;

    logic                 is_sample_c;
    logic                 is_dump_c;
    logic                 is_clean_c;
    logic                 sample_we_c;
    logic                 clean_entry_c;
    logic                 clean_we_c;
    logic [ADDR_SIZE-1:0] clean_addr_c;
    logic                 mode_lost_c;
    logic [ROW_W-1:0]     rd_row_c;
    logic [DATA_SIZE-1:0] rd_word_c;
    logic [ADDR_SIZE-1:0] next_rd_ptr_c;
    logic [ADDR_SIZE-1:0] next_wr_ptr_c;

    // Status decode, memory port selection and dump word selection.
    always_comb begin
        is_sample_c   = (bus.i_iagc_status == ST_SAMPLE);
        is_dump_c     = (bus.i_iagc_status == ST_DUMP);
        is_clean_c    = (bus.i_iagc_status == ST_CLEAN);
        sample_we_c   = is_sample_c && bus.i_sample_valid;
        clean_entry_c = (state == S_IDLE) && is_clean_c;
        clean_we_c    = clean_entry_c || ((state == S_CLEAN) && is_clean_c);
        clean_addr_c  = (state == S_CLEAN) ? clean_ptr : '0;
        mode_lost_c   = ((state == S_DUMP_FETCH || state == S_DUMP_SHOW ||
                          state == S_DUMP_DONE) && !is_dump_c) ||
                        ((state == S_CLEAN || state == S_CLEAN_DONE) && !is_clean_c);
        next_rd_ptr_c = (rd_ptr == LAST_ROW) ? '0 : rd_ptr + ADDR_SIZE'(1);
        next_wr_ptr_c = (wr_ptr == LAST_ROW) ? '0 : wr_ptr + ADDR_SIZE'(1);
        rd_row_c      = mem[rd_ptr];
        rd_word_c     = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (ch == CH_SIZE'(k)) begin
                rd_word_c = rd_row_c[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Storage array; sample writes and the clean sweep are mutually exclusive by status.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (sample_we_c) begin
                mem[wr_ptr] <= bus.i_sample_data;
            end else if (clean_we_c) begin
                mem[clean_addr_c] <= '0;
            end
        end
    end

    // Write pointer, fill level and sticky overflow.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clean_entry_c) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (sample_we_c) begin
            wr_ptr <= next_wr_ptr_c;
            if (count == DEPTH_CNT) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;

    // Dump / clean sequencer with registered stream and completion flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state              <= S_IDLE;
            rd_ptr             <= '0;
            rows_left          <= '0;
            ch                 <= '0;
            clean_ptr          <= '0;
            bus.o_dump_valid   <= 1'b0;
            bus.o_dump_data    <= '0;
            bus.o_dump_channel <= '0;
            bus.o_dump_last    <= 1'b0;
            bus.o_dump_end     <= 1'b0;
            bus.o_clean_end    <= 1'b0;
        end else if (mode_lost_c) begin
            state            <= S_IDLE;
            bus.o_dump_valid <= 1'b0;
            bus.o_dump_last  <= 1'b0;
            bus.o_dump_end   <= 1'b0;
            bus.o_clean_end  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_dump_c) begin
                        ch <= '0;
                        if (count == '0) begin
                            state          <= S_DUMP_DONE;
                            bus.o_dump_end <= 1'b1;
                        end else begin
                            state     <= S_DUMP_FETCH;
                            rd_ptr    <= (count == DEPTH_CNT) ? wr_ptr : '0;
                            rows_left <= count;
                        end
                    end else if (is_clean_c) begin
                        state     <= S_CLEAN;
                        clean_ptr <= ADDR_SIZE'(1);
                    end
                end
                S_DUMP_FETCH: begin
                    state              <= S_DUMP_SHOW;
                    bus.o_dump_valid   <= 1'b1;
                    bus.o_dump_data    <= rd_word_c;
                    bus.o_dump_channel <= ch;
                    bus.o_dump_last    <= (rows_left == CNT_W'(1)) && (ch == LAST_CH);
                end
                S_DUMP_SHOW: begin
                    if (bus.i_dump_ready) begin
                        bus.o_dump_valid <= 1'b0;
                        bus.o_dump_last  <= 1'b0;
                        if (bus.o_dump_last) begin
                            state          <= S_DUMP_DONE;
                            bus.o_dump_end <= 1'b1;
                        end else begin
                            state <= S_DUMP_FETCH;
                            if (ch == LAST_CH) begin
                                ch        <= '0;
                                rd_ptr    <= next_rd_ptr_c;
                                rows_left <= rows_left - CNT_W'(1);
                            end else begin
                                ch <= ch + CH_SIZE'(1);
                            end
                        end
                    end
                end
                S_DUMP_DONE: begin
                    bus.o_dump_end <= 1'b1;
                end
                S_CLEAN: begin
                    if (clean_ptr == LAST_ROW) begin
                        state <= S_CLEAN_DONE;
                    end else begin
                        clean_ptr <= clean_ptr + ADDR_SIZE'(1);
                    end
                end
                S_CLEAN_DONE: begin
                    bus.o_clean_end <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iagc_sample_buffer.sv
// Bench for iagc_sample_buffer: two configurations (2ch x 8 rows, 1ch x 4 rows)
// checked against queue-based reference models of the buffer contents.
module tb_iagc_sample_buffer;
    localparam logic [3:0] ST_IDLE   = 4'b0000;
    localparam logic [3:0] ST_SAMPLE = 4'b0011;
    localparam logic [3:0] ST_DUMP   = 4'b0111;
    localparam logic [3:0] ST_CLEAN  = 4'b1000;
    localparam int A_DEPTH = 8;
    localparam int B_DEPTH = 4;

    logic clk;
    logic rst;

    iagc_sample_buffer_if #(.DATA_SIZE(16), .NUM_CHANNELS(2), .CH_SIZE(1),
                            .ADDR_SIZE(3), .IAGC_STATUS_SIZE(4)) a_if ();
    iagc_sample_buffer_if #(.DATA_SIZE(16), .NUM_CHANNELS(1), .CH_SIZE(1),
                            .ADDR_SIZE(2), .IAGC_STATUS_SIZE(4)) b_if ();

    iagc_sample_buffer #(.DATA_SIZE(16), .NUM_CHANNELS(2), .CH_SIZE(1), .DEPTH(A_DEPTH),
                         .ADDR_SIZE(3), .IAGC_STATUS_SIZE(4))
        dut_a (.i_clock(clk), .i_reset(rst), .bus(a_if.slave));

    iagc_sample_buffer #(.DATA_SIZE(16), .NUM_CHANNELS(1), .CH_SIZE(1), .DEPTH(B_DEPTH),
                         .ADDR_SIZE(2), .IAGC_STATUS_SIZE(4))
        dut_b (.i_clock(clk), .i_reset(rst), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert;
    int          n_fail;
    logic [31:0] model_a[$];
    bit          ov_a;
    logic [15:0] model_b[$];
    bit          ov_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [31:0] row, input bit v);
        a_if.i_iagc_status  = ST_SAMPLE;
        a_if.i_sample_valid = v;
        a_if.i_sample_data  = row;
        tick();
        a_if.i_sample_valid = 1'b0;
        if (v) begin
            if (model_a.size() == A_DEPTH) begin
                ov_a = 1'b1;
                void'(model_a.pop_front());
            end
            model_a.push_back(row);
        end
    endtask

    task automatic write_b(input logic [15:0] w);
        b_if.i_iagc_status  = ST_SAMPLE;
        b_if.i_sample_valid = 1'b1;
        b_if.i_sample_data  = w;
        tick();
        b_if.i_sample_valid = 1'b0;
        if (model_b.size() == B_DEPTH) begin
            ov_b = 1'b1;
            void'(model_b.pop_front());
        end
        model_b.push_back(w);
    endtask

    // Full dump of A; optional 5-cycle stall at word hold_idx. Checks stream order and timing.
    task automatic dump_a(input int hold_idx);
        logic [15:0] exp_d[$];
        logic [0:0]  exp_c[$];
        int          idx;
        int          cycles;
        exp_d.delete();
        exp_c.delete();
        foreach (model_a[r]) begin
            exp_d.push_back(model_a[r][15:0]);
            exp_c.push_back(1'b0);
            exp_d.push_back(model_a[r][31:16]);
            exp_c.push_back(1'b1);
        end
        a_if.i_iagc_status = ST_DUMP;
        a_if.i_dump_ready  = 1'b1;
        idx    = 0;
        cycles = 0;
        while (a_if.o_dump_end !== 1'b1 && cycles < 400) begin
            if (a_if.o_dump_valid === 1'b1) begin
                if (idx >= exp_d.size()) begin
                    chk("a_extra_word", 32'(idx), 32'(exp_d.size()));
                end else begin
                    if (idx == hold_idx) begin
                        a_if.i_dump_ready = 1'b0;
                        repeat (5) begin
                            tick();
                            cycles++;
                            chk("a_hold_valid", 32'(a_if.o_dump_valid), 32'(1));
                            chk("a_hold_data", 32'(a_if.o_dump_data), 32'(exp_d[idx]));
                            chk("a_hold_chan", 32'(a_if.o_dump_channel), 32'(exp_c[idx]));
                            chk("a_hold_last", 32'(a_if.o_dump_last),
                                32'(idx == exp_d.size() - 1));
                        end
                        a_if.i_dump_ready = 1'b1;
                    end
                    chk("a_dump_data", 32'(a_if.o_dump_data), 32'(exp_d[idx]));
                    chk("a_dump_chan", 32'(a_if.o_dump_channel), 32'(exp_c[idx]));
                    chk("a_dump_last", 32'(a_if.o_dump_last), 32'(idx == exp_d.size() - 1));
                end
                idx++;
            end
            tick();
            cycles++;
        end
        chk("a_dump_end", 32'(a_if.o_dump_end), 32'(1));
        chk("a_dump_words", 32'(idx), 32'(exp_d.size()));
        if (hold_idx < 0) begin
            chk("a_dump_cycles", 32'(cycles), 32'(1 + 2 * exp_d.size()));
        end
        tick();
        chk("a_dump_end_held", 32'(a_if.o_dump_end), 32'(1));
        chk("a_count_after_dump", 32'(a_if.o_count), 32'(model_a.size()));
        chk("a_ovf_after_dump", 32'(a_if.o_overflow), 32'(ov_a));
        a_if.i_iagc_status = ST_IDLE;
        tick();
        chk("a_dump_end_drop", 32'(a_if.o_dump_end), 32'(0));
    endtask

    task automatic dump_b();
        int idx;
        int cycles;
        b_if.i_iagc_status = ST_DUMP;
        b_if.i_dump_ready  = 1'b1;
        idx    = 0;
        cycles = 0;
        while (b_if.o_dump_end !== 1'b1 && cycles < 200) begin
            if (b_if.o_dump_valid === 1'b1) begin
                if (idx >= model_b.size()) begin
                    chk("b_extra_word", 32'(idx), 32'(model_b.size()));
                end else begin
                    chk("b_dump_data", 32'(b_if.o_dump_data), 32'(model_b[idx]));
                    chk("b_dump_chan", 32'(b_if.o_dump_channel), 32'(0));
                    chk("b_dump_last", 32'(b_if.o_dump_last), 32'(idx == model_b.size() - 1));
                end
                idx++;
            end
            tick();
            cycles++;
        end
        chk("b_dump_end", 32'(b_if.o_dump_end), 32'(1));
        chk("b_dump_words", 32'(idx), 32'(model_b.size()));
        b_if.i_iagc_status = ST_IDLE;
        tick();
    endtask

    initial begin
        int hs;
        int guard;
        n_assert = 0;
        n_fail   = 0;
        ov_a     = 1'b0;
        ov_b     = 1'b0;
        rst      = 1'b1;
        a_if.i_iagc_status = ST_IDLE;
        a_if.i_sample_valid = 1'b0;
        a_if.i_sample_data  = '0;
        a_if.i_dump_ready   = 1'b0;
        b_if.i_iagc_status = ST_IDLE;
        b_if.i_sample_valid = 1'b0;
        b_if.i_sample_data  = '0;
        b_if.i_dump_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", 32'(a_if.o_dump_valid), 32'(0));
        chk("rst_last", 32'(a_if.o_dump_last), 32'(0));
        chk("rst_dump_end", 32'(a_if.o_dump_end), 32'(0));
        chk("rst_clean_end", 32'(a_if.o_clean_end), 32'(0));
        chk("rst_count", 32'(a_if.o_count), 32'(0));
        chk("rst_ovf", 32'(a_if.o_overflow), 32'(0));
        chk("rst_count_b", 32'(b_if.o_count), 32'(0));

        // Full clean of the 8-row buffer: flag rises on the 9th edge.
        a_if.i_iagc_status = ST_CLEAN;
        repeat (8) tick();
        chk("clean_end_8", 32'(a_if.o_clean_end), 32'(0));
        tick();
        chk("clean_end_9", 32'(a_if.o_clean_end), 32'(1));
        tick();
        chk("clean_end_hold", 32'(a_if.o_clean_end), 32'(1));
        a_if.i_iagc_status = ST_IDLE;
        tick();
        chk("clean_end_drop", 32'(a_if.o_clean_end), 32'(0));
        chk("clean_count", 32'(a_if.o_count), 32'(0));
        dump_a(-1);

        // Three two-channel rows, dumped oldest-first.
        write_a(32'h000B_000A, 1'b1);
        write_a(32'h001B_001A, 1'b1);
        write_a(32'h002B_002A, 1'b1);
        chk("count_3", 32'(a_if.o_count), 32'(3));
        a_if.i_iagc_status  = ST_IDLE;
        a_if.i_sample_valid = 1'b1;
        tick();
        a_if.i_sample_valid = 1'b0;
        chk("no_write_outside_sample", 32'(a_if.o_count), 32'(3));
        dump_a(-1);

        // Random rows with random strobes, then forced writes into overflow.
        for (int i = 0; i < 6; i++) begin
            write_a($urandom(), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 9; i++) begin
            write_a($urandom(), 1'b1);
        end
        chk("count_sat", 32'(a_if.o_count), 32'(model_a.size()));
        chk("ovf_set", 32'(a_if.o_overflow), 32'(ov_a));
        dump_a(-1);

        // Backpressure stall on a mid-stream word.
        dump_a(5);

        // Abort after two handshakes, then a fresh dump restarts from the oldest word.
        a_if.i_iagc_status = ST_DUMP;
        a_if.i_dump_ready  = 1'b1;
        hs    = 0;
        guard = 0;
        while (hs < 2 && guard < 100) begin
            if (a_if.o_dump_valid === 1'b1) hs++;
            tick();
            guard++;
        end
        chk("abort_handshakes", 32'(hs), 32'(2));
        a_if.i_iagc_status = ST_IDLE;
        tick();
        chk("abort_valid_drop", 32'(a_if.o_dump_valid), 32'(0));
        chk("abort_count", 32'(a_if.o_count), 32'(model_a.size()));
        dump_a(-1);

        // Single-channel 4-row wrap: values 1..6 leave 3..6.
        for (int v = 1; v <= 6; v++) begin
            write_b(16'(v));
        end
        chk("b_count", 32'(b_if.o_count), 32'(4));
        chk("b_ovf", 32'(b_if.o_overflow), 32'(1));
        b_if.i_iagc_status = ST_IDLE;
        tick();
        dump_b();
        for (int i = 0; i < 3; i++) begin
            write_b(16'($urandom()));
        end
        b_if.i_iagc_status = ST_IDLE;
        tick();
        dump_b();

        // Reset in the middle of a clean sweep.
        a_if.i_iagc_status = ST_CLEAN;
        tick();
        chk("clean_entry_count", 32'(a_if.o_count), 32'(0));
        chk("clean_entry_ovf", 32'(a_if.o_overflow), 32'(0));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midclean_rst_count", 32'(a_if.o_count), 32'(0));
        chk("midclean_rst_clean_end", 32'(a_if.o_clean_end), 32'(0));
        chk("midclean_rst_valid", 32'(a_if.o_dump_valid), 32'(0));
        rst = 1'b0;
        a_if.i_iagc_status = ST_IDLE;
        tick();
        chk("midclean_clean_end_stays", 32'(a_if.o_clean_end), 32'(0));
        model_a.delete();
        ov_a = 1'b0;
        dump_a(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
